// File: rtl/fetch_pc_arbiter.sv
// fetch_pc_arbiter
//
// Owns the front-end fetch PC and picks one redirect per cycle from the
// retire flush, the branch mispredict and the jump handler, in that order of
// priority. Sequences the fetch stream through BOOT -> RUN, inserts
// fetch-invalid bubble cycles after every redirect, and holds the PC while
// the jump handler or the decode queue stalls.
//
// Parameters
//   RESET_PC       PC loaded on reset and fetched first
//   FETCH_WIDTH    instructions per fetch group (PC increment, instruction-addressed)
//   BUBBLE_CYCLES  fetch-invalid cycles after a redirect (0..15)
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   flush_req_i / flush_target_i      retire flush pulse and target
//   mispred_req_i / mispred_target_i  branch mispredict pulse and target
//   jump_req_i / jump_target_i        resolved jump pulse and target
//   stall_jump_i, stall_dec_i         downstream stall sources
//   pc_o, fetch_valid_o               fetch group address and its valid
//   squash_o                          kills the groups in the fetch/decode latch
//   flush_ack_o, mispred_ack_o, jump_ack_o  accepted-redirect pulses
//   fsm_state_o                       debug state (BOOT=0, RUN=1, BUBBLE=2)
//   stall_cycles_o                    saturating count of stalled RUN cycles

module fetch_pc_arbiter #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int          FETCH_WIDTH   = 4,
    parameter int          BUBBLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_req_i,
    input  logic [15:0] flush_target_i,
    input  logic        mispred_req_i,
    input  logic [15:0] mispred_target_i,
    input  logic        jump_req_i,
    input  logic [15:0] jump_target_i,
    input  logic        stall_jump_i,
    input  logic        stall_dec_i,
    output logic [15:0] pc_o,
    output logic        fetch_valid_o,
    output logic        squash_o,
    output logic        flush_ack_o,
    output logic        mispred_ack_o,
    output logic        jump_ack_o,
    output logic [1:0]  fsm_state_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    localparam logic [15:0] PC_STEP       = 16'(FETCH_WIDTH);
    localparam logic [3:0]  BUBBLE_RELOAD = (BUBBLE_CYCLES > 0) ? 4'(BUBBLE_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        fetchValid_q, fetchValid_d;
    logic        squash_q, squash_d;
    logic        flushAck_q, flushAck_d;
    logic        mispredAck_q, mispredAck_d;
    logic        jumpAck_q, jumpAck_d;
    logic [3:0]  bubbleCnt_q, bubbleCnt_d;
    logic [15:0] stallCycles_q, stallCycles_d;

    logic        stall;
    logic        redirect;
    logic [15:0] redirectTarget;

    assign stall    = stall_jump_i | stall_dec_i;
    assign redirect = flush_req_i | mispred_req_i | jump_req_i;

    // Fixed priority: losers are simply dropped, they belong to the killed path.
    always_comb begin
        redirectTarget = jump_target_i;
        if (flush_req_i) begin
            redirectTarget = flush_target_i;
        end else if (mispred_req_i) begin
            redirectTarget = mispred_target_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetchValid_d  = fetchValid_q;
        squash_d      = 1'b0;
        flushAck_d    = 1'b0;
        mispredAck_d  = 1'b0;
        jumpAck_d     = 1'b0;
        bubbleCnt_d   = bubbleCnt_q;
        stallCycles_d = stallCycles_q;

        // A redirect wins over every state and over any stall.
        if (redirect) begin
            pc_d         = redirectTarget;
            squash_d     = 1'b1;
            flushAck_d   = flush_req_i;
            mispredAck_d = mispred_req_i & ~flush_req_i;
            jumpAck_d    = jump_req_i & ~flush_req_i & ~mispred_req_i;
            if (BUBBLE_CYCLES > 0) begin
                fetchValid_d = 1'b0;
                bubbleCnt_d  = BUBBLE_RELOAD;
                state_d      = BUBBLE;
            end else begin
                fetchValid_d = 1'b1;
                state_d      = RUN;
            end
        end else begin
            unique case (state_q)
                BOOT: begin
                    fetchValid_d = 1'b1;
                    state_d      = RUN;
                end
                RUN: begin
                    fetchValid_d = 1'b1;
                    if (stall) begin
                        if (stallCycles_q != 16'hFFFF) begin
                            stallCycles_d = stallCycles_q + 16'd1;
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                BUBBLE: begin
                    fetchValid_d = 1'b0;
                    if (bubbleCnt_q == 4'd0) begin
                        fetchValid_d = 1'b1;
                        state_d      = RUN;
                    end else begin
                        bubbleCnt_d = bubbleCnt_q - 4'd1;
                    end
                end
                default: begin
                    fetchValid_d = 1'b0;
                    state_d      = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetchValid_q  <= 1'b0;
            squash_q      <= 1'b0;
            flushAck_q    <= 1'b0;
            mispredAck_q  <= 1'b0;
            jumpAck_q     <= 1'b0;
            bubbleCnt_q   <= 4'd0;
            stallCycles_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetchValid_q  <= fetchValid_d;
            squash_q      <= squash_d;
            flushAck_q    <= flushAck_d;
            mispredAck_q  <= mispredAck_d;
            jumpAck_q     <= jumpAck_d;
            bubbleCnt_q   <= bubbleCnt_d;
            stallCycles_q <= stallCycles_d;
        end
    end

    assign pc_o           = pc_q;
    assign fetch_valid_o  = fetchValid_q;
    assign squash_o       = squash_q;
    assign flush_ack_o    = flushAck_q;
    assign mispred_ack_o  = mispredAck_q;
    assign jump_ack_o     = jumpAck_q;
    assign fsm_state_o    = state_q;
    assign stall_cycles_o = stallCycles_q;

endmodule

// File: tb/tb_fetch_pc_arbiter.sv
// tb_fetch_pc_arbiter
//
// Drives two instances of fetch_pc_arbiter from shared request/stall inputs:
//   dutA  default parameters (RESET_PC=0000, BUBBLE_CYCLES=1)
//   dutB  RESET_PC=FFF8, BUBBLE_CYCLES=2
// Each instance has its own reset so only one of them is exercised at a time.
// Expected outputs come from hand-derived vector tables; each vector's
// expectation is queued when its inputs are driven and popped when the
// registered outputs are sampled after the following rising edge.

module tb_fetch_pc_arbiter;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

    localparam logic [2:0] ACK_NONE = 3'b000;
    localparam logic [2:0] ACK_FL   = 3'b100;
    localparam logic [2:0] ACK_MP   = 3'b010;
    localparam logic [2:0] ACK_JP   = 3'b001;

    typedef struct packed {
        logic [15:0] pc;
        logic        fv;
        logic        sq;
        logic [2:0]  ack;
        logic [1:0]  state;
        logic [15:0] sc;
    } obs_t;

    typedef struct {
        logic        flush;
        logic [15:0] flushTgt;
        logic        mis;
        logic [15:0] misTgt;
        logic        jmp;
        logic [15:0] jmpTgt;
        logic        stallJ;
        logic        stallD;
        obs_t        exp;
    } vec_t;

    typedef struct {
        bit    useB;
        obs_t  exp;
        string tag;
    } expect_t;

    logic        clk = 1'b0;
    logic        rstA, rstB;
    logic        flushReq, misReq, jmpReq, stallJump, stallDec;
    logic [15:0] flushTgt, misTgt, jmpTgt;

    logic [15:0] pcA, scA, pcB, scB;
    logic        fvA, sqA, faA, maA, jaA;
    logic        fvB, sqB, faB, maB, jaB;
    logic [1:0]  stA, stB;
    obs_t        obsA, obsB;

    expect_t     expQ[$];
    vec_t        tableA[$];
    vec_t        tableB[$];
    int          vecCount  = 0;
    int          missCount = 0;

    always #5 clk = ~clk;

    fetch_pc_arbiter dutA (
        .clk_i(clk), .rst_i(rstA),
        .flush_req_i(flushReq), .flush_target_i(flushTgt),
        .mispred_req_i(misReq), .mispred_target_i(misTgt),
        .jump_req_i(jmpReq), .jump_target_i(jmpTgt),
        .stall_jump_i(stallJump), .stall_dec_i(stallDec),
        .pc_o(pcA), .fetch_valid_o(fvA), .squash_o(sqA),
        .flush_ack_o(faA), .mispred_ack_o(maA), .jump_ack_o(jaA),
        .fsm_state_o(stA), .stall_cycles_o(scA)
    );

    fetch_pc_arbiter #(.RESET_PC(16'hFFF8), .FETCH_WIDTH(4), .BUBBLE_CYCLES(2)) dutB (
        .clk_i(clk), .rst_i(rstB),
        .flush_req_i(flushReq), .flush_target_i(flushTgt),
        .mispred_req_i(misReq), .mispred_target_i(misTgt),
        .jump_req_i(jmpReq), .jump_target_i(jmpTgt),
        .stall_jump_i(stallJump), .stall_dec_i(stallDec),
        .pc_o(pcB), .fetch_valid_o(fvB), .squash_o(sqB),
        .flush_ack_o(faB), .mispred_ack_o(maB), .jump_ack_o(jaB),
        .fsm_state_o(stB), .stall_cycles_o(scB)
    );

    assign obsA = {pcA, fvA, sqA, {faA, maA, jaA}, stA, scA};
    assign obsB = {pcB, fvB, sqB, {faB, maB, jaB}, stB, scB};

    function automatic obs_t mkObs(input logic [15:0] pc, input logic fv, input logic sq,
                                   input logic [2:0] ack, input logic [1:0] st, input logic [15:0] sc);
        obs_t o;
        o.pc    = pc;
        o.fv    = fv;
        o.sq    = sq;
        o.ack   = ack;
        o.state = st;
        o.sc    = sc;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic f, input logic [15:0] ft,
                                   input logic m, input logic [15:0] mt,
                                   input logic j, input logic [15:0] jt,
                                   input logic sj, input logic sd,
                                   input obs_t e);
        vec_t v;
        v.flush    = f;
        v.flushTgt = ft;
        v.mis      = m;
        v.misTgt   = mt;
        v.jmp      = j;
        v.jmpTgt   = jt;
        v.stallJ   = sj;
        v.stallD   = sd;
        v.exp      = e;
        return v;
    endfunction

    // Idle inputs, only the expected outputs matter.
    function automatic vec_t idle(input obs_t e);
        return mkVec(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, e);
    endfunction

    task automatic applyStimulus(input vec_t v, input bit useB, input string tag);
        expect_t e;
        flushReq  = v.flush;
        flushTgt  = v.flushTgt;
        misReq    = v.mis;
        misTgt    = v.misTgt;
        jmpReq    = v.jmp;
        jmpTgt    = v.jmpTgt;
        stallJump = v.stallJ;
        stallDec  = v.stallD;
        e.useB = useB;
        e.exp  = v.exp;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        obs_t    act;
        vecCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard: no expectation queued when output sampled");
        end else begin
            e   = expQ.pop_front();
            act = e.useB ? obsB : obsA;
            if (act !== e.exp) begin
                missCount++;
                $display("[TB] FAIL %s: got pc=%h fv=%b sq=%b ack(f,m,j)=%b st=%0d sc=%0d, want pc=%h fv=%b sq=%b ack(f,m,j)=%b st=%0d sc=%0d",
                         e.tag, act.pc, act.fv, act.sq, act.ack, act.state, act.sc,
                         e.exp.pc, e.exp.fv, e.exp.sq, e.exp.ack, e.exp.state, e.exp.sc);
            end
        end
    endtask

    // Checks the current outputs without waiting for a clock edge.
    task automatic expectNow(input obs_t o, input bit useB, input string tag);
        expect_t e;
        e.useB = useB;
        e.exp  = o;
        e.tag  = tag;
        expQ.push_back(e);
        checkOutput();
    endtask

    // Drives one vector, lets one rising edge pass, checks, then parks on the falling edge.
    task automatic runVector(input vec_t v, input bit useB, input string tag);
        applyStimulus(v, useB, tag);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // dutA: boot, stalls from both sources, jump, simultaneous and back-to-back redirects
        tableA.push_back(idle(mkObs(16'h0000, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableA.push_back(idle(mkObs(16'h0004, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableA.push_back(idle(mkObs(16'h0008, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        for (int k = 1; k <= 3; k++)
            tableA.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, mkObs(16'h0008, 1, 0, ACK_NONE, ST_RUN, 16'(k))));
        tableA.push_back(idle(mkObs(16'h000C, 1, 0, ACK_NONE, ST_RUN, 16'd3)));
        for (int k = 4; k <= 6; k++)
            tableA.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, mkObs(16'h000C, 1, 0, ACK_NONE, ST_RUN, 16'(k))));
        tableA.push_back(idle(mkObs(16'h0010, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(mkVec(0, 0, 0, 0, 1, 16'h0040, 0, 0, mkObs(16'h0040, 0, 1, ACK_JP, ST_BUBBLE, 16'd6)));
        tableA.push_back(idle(mkObs(16'h0040, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(idle(mkObs(16'h0044, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(mkVec(1, 16'h0100, 1, 16'h0200, 1, 16'h0300, 0, 0, mkObs(16'h0100, 0, 1, ACK_FL, ST_BUBBLE, 16'd6)));
        tableA.push_back(idle(mkObs(16'h0100, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(idle(mkObs(16'h0104, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(idle(mkObs(16'h0108, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(mkVec(0, 0, 1, 16'h0500, 0, 0, 0, 1, mkObs(16'h0500, 0, 1, ACK_MP, ST_BUBBLE, 16'd6)));
        tableA.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, mkObs(16'h0500, 1, 0, ACK_NONE, ST_RUN, 16'd6)));
        tableA.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, mkObs(16'h0500, 1, 0, ACK_NONE, ST_RUN, 16'd7)));
        tableA.push_back(idle(mkObs(16'h0504, 1, 0, ACK_NONE, ST_RUN, 16'd7)));
        tableA.push_back(mkVec(0, 0, 0, 0, 1, 16'h0600, 0, 0, mkObs(16'h0600, 0, 1, ACK_JP, ST_BUBBLE, 16'd7)));
        tableA.push_back(mkVec(0, 0, 0, 0, 1, 16'h0610, 0, 0, mkObs(16'h0610, 0, 1, ACK_JP, ST_BUBBLE, 16'd7)));
        tableA.push_back(idle(mkObs(16'h0610, 1, 0, ACK_NONE, ST_RUN, 16'd7)));
        tableA.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 1, mkObs(16'h0610, 1, 0, ACK_NONE, ST_RUN, 16'd8)));
        tableA.push_back(idle(mkObs(16'h0614, 1, 0, ACK_NONE, ST_RUN, 16'd8)));
        tableA.push_back(mkVec(0, 0, 1, 16'h0700, 1, 16'h0800, 0, 0, mkObs(16'h0700, 0, 1, ACK_MP, ST_BUBBLE, 16'd8)));
        tableA.push_back(idle(mkObs(16'h0700, 1, 0, ACK_NONE, ST_RUN, 16'd8)));

        // dutB: wrap from FFF8, two-cycle bubble, redirect inside the bubble
        tableB.push_back(idle(mkObs(16'hFFF8, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(idle(mkObs(16'hFFFC, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(idle(mkObs(16'h0000, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(idle(mkObs(16'h0004, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(mkVec(0, 0, 1, 16'h0080, 0, 0, 0, 0, mkObs(16'h0080, 0, 1, ACK_MP, ST_BUBBLE, 16'd0)));
        tableB.push_back(mkVec(1, 16'h00C0, 0, 0, 0, 0, 0, 0, mkObs(16'h00C0, 0, 1, ACK_FL, ST_BUBBLE, 16'd0)));
        tableB.push_back(idle(mkObs(16'h00C0, 0, 0, ACK_NONE, ST_BUBBLE, 16'd0)));
        tableB.push_back(idle(mkObs(16'h00C0, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(idle(mkObs(16'h00C4, 1, 0, ACK_NONE, ST_RUN, 16'd0)));
        tableB.push_back(mkVec(0, 0, 0, 0, 1, 16'h0200, 0, 0, mkObs(16'h0200, 0, 1, ACK_JP, ST_BUBBLE, 16'd0)));

        rstA = 1'b1;
        rstB = 1'b1;
        applyStimulus(idle(mkObs(16'h0, 0, 0, ACK_NONE, ST_BOOT, 16'd0)), 1'b0, "discard");
        void'(expQ.pop_front());

        #12;
        expectNow(mkObs(16'h0000, 0, 0, ACK_NONE, ST_BOOT, 16'd0), 1'b0, "resetA");
        expectNow(mkObs(16'hFFF8, 0, 0, ACK_NONE, ST_BOOT, 16'd0), 1'b1, "resetB");

        @(negedge clk);
        rstA = 1'b0;
        #1;
        expectNow(mkObs(16'h0000, 0, 0, ACK_NONE, ST_BOOT, 16'd0), 1'b0, "bootA");
        foreach (tableA[i]) runVector(tableA[i], 1'b0, $sformatf("A[%0d]", i));

        rstB = 1'b0;
        foreach (tableB[i]) runVector(tableB[i], 1'b1, $sformatf("B[%0d]", i));

        // dutB is mid-bubble here; reset must act without waiting for an edge.
        applyStimulus(idle(mkObs(16'hFFF8, 0, 0, ACK_NONE, ST_BOOT, 16'd0)), 1'b1, "asyncResetB");
        #2;
        rstB = 1'b1;
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        expectNow(mkObs(16'hFFF8, 0, 0, ACK_NONE, ST_BOOT, 16'd0), 1'b1, "heldResetB");
        @(negedge clk);
        rstB = 1'b0;
        runVector(idle(mkObs(16'hFFF8, 1, 0, ACK_NONE, ST_RUN, 16'd0)), 1'b1, "rebootB0");
        runVector(idle(mkObs(16'hFFFC, 1, 0, ACK_NONE, ST_RUN, 16'd0)), 1'b1, "rebootB1");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/fetch_pc_arbiter.md
# fetch_pc_arbiter

Owns the front-end fetch PC register and arbitrates every PC redirect source each cycle. The sources are a retire-time flush, a branch mispredict, and the jump handler's resolved jump (`jump_for_pcsel` / `jump_addr_pc`). It sequences the fetch stream through boot, run and post-redirect bubble states and holds the PC while downstream stalls. It sits between the redirect producers and the 4-wide instruction fetch/decode latch.

## Interface
- `RESET_PC`, default 16'h0000, is the PC loaded on reset and fetched first.
- `FETCH_WIDTH`, default 4, is the number of instructions per fetch group. This is the PC increment; PC is instruction-addressed.
- `BUBBLE_CYCLES`, default 1, is the number of fetch-invalid cycles after a redirect (0–15).
- `clk`  in  1  is the sole clock; all state updates on the rising edge.
- `rst`  in  1  is the reset. It is asynchronous and active-high.
- `flush_req`  in  1  is a 1-cycle pulse requesting a retire flush.
- `flush_target`  in  16  is the flush PC.
- `mispred_req`  in  1  is a 1-cycle pulse for a branch mispredict redirect.
- `mispred_target`  in  16  is the corrected branch PC.
- `jump_req`  in  1  is a 1-cycle pulse for a jump redirect (from the jump handler).
- `jump_target`  in  16  is the jump PC.
- `stall_jump`  in  1  is the jump handler waiting on a register jump base.
- `stall_dec`  in  1  indicates the decode/issue queue cannot accept a group.
- `pc`  out  16  is the address of the fetch group presented this cycle.
- `fetch_valid`  out  1  means the group at `pc` is valid.
- `squash`  out  1  is a 1-cycle pulse that kills the groups in the fetch/decode latch.
- `flush_ack`, `mispred_ack`, `jump_ack`  out  1 each  are 1-cycle pulses that mark the accepted redirect.
- `fsm_state`  out  2  is the debug encoding: BOOT=0, RUN=1, BUBBLE=2.
- `stall_cycles`  out  16  is a saturating count of stalled RUN cycles.

## Operation
- All outputs are registered.
- Reset values: `pc`=RESET_PC, `fetch_valid`=0, `squash`=0, all acks 0, `fsm_state`=BOOT, `stall_cycles`=0, bubble counter 0.
- Arbitration priority is flush > mispred > jump, and is evaluated every cycle in every state.
- Losing simultaneous requests are dropped, with no ack and no retention. They belong to the killed younger path.
- Requesters guarantee 1-cycle pulses. A request held high re-triggers every cycle.
- A redirect accepted at edge E does the following at E:
  - `pc` loads the winner's target.
  - `squash` and the winner's ack are set to 1.
  - If BUBBLE_CYCLES>0, `fetch_valid` is set to 0, the bubble counter loads BUBBLE_CYCLES−1, and the FSM enters BUBBLE.
  - If BUBBLE_CYCLES=0, `fetch_valid` is set to 1 and the FSM enters RUN.
- `squash` and the acks clear at the next edge unless another redirect is accepted.
- The stall signal is `stall = stall_jump | stall_dec`.
- A redirect always overrides a stall.
- BOOT: the first edge after reset deassertion moves the FSM to RUN and sets `fetch_valid`=1, with `pc` unchanged at RESET_PC.
- RUN, no redirect:
  - If `stall`: `pc` holds, `fetch_valid` stays 1 (the group is re-presented), and `stall_cycles` increments, saturating at 16'hFFFF.
  - Otherwise `pc` <= `pc` + FETCH_WIDTH, computed modulo 2^16.
- BUBBLE, no redirect:
  - `pc` holds and `fetch_valid`=0.
  - `stall` is ignored and not counted.
  - When the counter reaches 0, the next edge enters RUN with `fetch_valid`=1, still at the redirect target. Otherwise the counter decrements.
- A redirect during BUBBLE reloads `pc`, restarts the counter, and re-pulses `squash` and the ack.
- A redirect during BOOT is accepted normally and BOOT is exited.
- A group is consumed when `fetch_valid` is high and `stall` is low in the same cycle.

## Timing
- Redirect latency: a request sampled at edge E gives `pc`=target from E.
- With BUBBLE_CYCLES=B, `fetch_valid` rises B edges after E.
- PC advance latency is 1 edge per consumed group.
- Wrap: 16'hFFFC + 4 = 16'h0000, with no flag.
- Asserting `rst` mid-operation immediately and asynchronously forces all reset values. Pending bubbles are discarded.
- Deasserting `rst` takes effect at the next rising edge (BOOT→RUN).

## Test plan
- Reset/boot: release `rst`. First cycle shows `pc`=0000, `fetch_valid`=0, state BOOT. Following cycles show `pc`=0000, 0004, 0008, each with `fetch_valid`=1.
- Stall: with `pc`=0008, hold `stall_dec` for 3 cycles. `pc` stays 0008 for 4 presented cycles, `stall_cycles`=3, then `pc`=000C. Repeat using `stall_jump` and expect identical behaviour.
- Jump redirect: pulse `jump_req` with target 0040 while running at 0010. The next cycle shows `pc`=0040, `squash`=1, `jump_ack`=1, `fetch_valid`=0. It then runs at 0040 and 0044 with `fetch_valid`=1.
- Simultaneous redirects: pulse flush=0100, mispred=0200 and jump=0300 in the same cycle. Result is `pc`=0100 with only `flush_ack`=1. The 0200 and 0300 targets never appear later.
- Redirect during bubble and under stall:
  - Set BUBBLE_CYCLES=2. Mispredict to 0080, then flush to 00C0 one cycle later. Expect `pc`=00C0, a second `squash` pulse, and `fetch_valid` rising 2 cycles after the flush.
  - Redirect while `stall_dec`=1. It must still be taken.
- Wrap and mid-op reset:
  - RESET_PC=FFF8 gives FFF8, FFFC, 0000.
  - Assert `rst` in the middle of a BUBBLE. All outputs return to reset values asynchronously, and the sequence resumes at RESET_PC.
